// File: rtl/stage_pkg.sv
// rtl/stage_pkg.sv - shared types and defaults for the stage skid buffer
package stage_pkg;

    localparam int DATA_W = 24;

    // Encoding equals the number of held words, so occupancy is a direct decode.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    function automatic logic [1:0] occupancy_of(input stage_state_t st);
        case (st)
            EMPTY:   occupancy_of = 2'd0;
            BUSY:    occupancy_of = 2'd1;
            FULL:    occupancy_of = 2'd2;
            default: occupancy_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/stage_skid_buffer_if.sv
// rtl/stage_skid_buffer_if.sv - upstream/downstream valid-ready handshake bundle
interface stage_skid_buffer_if #(
    parameter int N = stage_pkg::DATA_W
);
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_ready;

    // The buffer itself.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );

    // The surrounding pipeline: producer on the in side, consumer on the out side.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/skid_entry.sv
// rtl/skid_entry.sv - N-bit data register with synchronous active-low clear and load enable
module skid_entry #(
    parameter int N = stage_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/stage_skid_buffer.sv
// rtl/stage_skid_buffer.sv - two-entry skid buffer decoupling ready timing between pipeline stages
module stage_skid_buffer
    import stage_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    stage_skid_buffer_if.slave        bus,
    output logic [1:0]                occupancy
);

    stage_state_t state;
    stage_state_t state_nxt;

    logic         main_load;
    logic         skid_load;
    logic [N-1:0] main_d;
    logic [N-1:0] main_q;
    logic [N-1:0] skid_q;
    logic         entry_clr_n;

    // Reset and flush both wipe the data entries; reset simply wins by being folded in.
    assign entry_clr_n = rst && !flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = bus.in_data;
        case (state)
            EMPTY: begin
                if (bus.in_valid) begin
                    state_nxt = BUSY;
                    main_load = 1'b1;
                end
            end
            BUSY: begin
                if (bus.in_valid && bus.out_ready) begin
                    main_load = 1'b1;
                end else if (bus.in_valid) begin
                    state_nxt = FULL;
                    skid_load = 1'b1;
                end else if (bus.out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so upstream data is never looked at.
                if (bus.out_ready) begin
                    state_nxt = BUSY;
                    main_load = 1'b1;
                    main_d    = skid_q;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    skid_entry #(.N(N)) u_main (
        .clk   (clk),
        .clr_n (entry_clr_n),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    skid_entry #(.N(N)) u_skid (
        .clk   (clk),
        .clr_n (entry_clr_n),
        .load  (skid_load),
        .d     (bus.in_data),
        .q     (skid_q)
    );

    // All handshake outputs come from registers only, breaking the ready/valid comb chain.
    assign bus.in_ready  = (state != FULL);
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_data  = main_q;
    assign occupancy     = occupancy_of(state);

endmodule

// File: tb/tb_stage_skid_buffer.sv
// tb/tb_stage_skid_buffer.sv - randomized and directed bench for stage_skid_buffer against a queue model
module tb_stage_skid_buffer;
    import stage_pkg::*;

    localparam int N = DATA_W;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [1:0] occupancy;

    stage_skid_buffer_if #(.N(N)) bus ();

    stage_skid_buffer #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    logic [N-1:0] mq[$];
    logic [N-1:0] m_main;
    int           n_vec = 0;
    int           n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare at negedge.
    task automatic cycle(input logic r, input logic fl, input logic iv,
                         input logic [N-1:0] d, input logic ordy);
        bit push;
        bit pop;
        rst           = r;
        flush         = fl;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        if (!r || fl) begin
            mq.delete();
            m_main = '0;
        end else begin
            push = iv && (mq.size() < 2);
            pop  = ordy && (mq.size() > 0);
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(d);
            if (mq.size() > 0) m_main = mq[0];
        end
        @(posedge clk);
        @(negedge clk);
        check("in_ready",  32'(bus.in_ready),  32'(mq.size() < 2));
        check("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
        check("occupancy", 32'(occupancy),     32'(mq.size()));
        check("out_data",  32'(bus.out_data),  32'(m_main));
    endtask

    initial begin
        rst           = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        m_main        = '0;

        // reset held two cycles with traffic offered
        cycle(1'b0, 1'b0, 1'b1, 24'hABCDEF, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 24'hABCDEF, 1'b0);
        check("rst_out_data", 32'(bus.out_data), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);

        // single pass
        cycle(1'b1, 1'b0, 1'b1, 24'h000123, 1'b1);
        check("single_valid", 32'(bus.out_valid), 32'h1);
        check("single_data",  32'(bus.out_data),  32'h000123);
        cycle(1'b1, 1'b0, 1'b0, 24'h0, 1'b1);
        check("single_empty", 32'(occupancy), 32'h0);

        // backpressure
        cycle(1'b1, 1'b0, 1'b1, 24'h000001, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 24'h000002, 1'b0);
        check("bp_occ2",  32'(occupancy),    32'h2);
        check("bp_ready", 32'(bus.in_ready), 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 24'h000003, 1'b0);
        check("bp_head1", 32'(bus.out_data), 32'h000001);
        cycle(1'b1, 1'b0, 1'b0, 24'h0, 1'b1);
        check("bp_head2", 32'(bus.out_data), 32'h000002);
        cycle(1'b1, 1'b0, 1'b0, 24'h0, 1'b1);
        check("bp_drained", 32'(occupancy), 32'h0);

        // streaming at full rate
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 1'b1, N'(i), 1'b1);
            check("stream_data",  32'(bus.out_data), 32'(i));
            check("stream_ready", 32'(bus.in_ready), 32'h1);
        end
        cycle(1'b1, 1'b0, 1'b0, 24'h0, 1'b1);

        // flush while full with a concurrent offer
        cycle(1'b1, 1'b0, 1'b1, 24'h0000AA, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 24'h0000BB, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 24'h0000CC, 1'b1);
        check("flush_valid", 32'(bus.out_valid), 32'h0);
        check("flush_data",  32'(bus.out_data),  32'h0);
        cycle(1'b1, 1'b0, 1'b0, 24'h0, 1'b1);
        check("flush_stays_empty", 32'(bus.out_valid), 32'h0);

        // random toggling against the queue model
        for (int i = 0; i < 1000; i++) begin
            logic r;
            logic fl;
            r  = ($urandom_range(0, 199) != 0);
            fl = ($urandom_range(0, 63) == 0);
            cycle(r, fl, 1'($urandom_range(0, 1)), N'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stage_skid_buffer.md
STAGE_SKID_BUFFER -- requirements
Module: stage_skid_buffer

Interface
REQ-001 SHALL have parameter N, default 24, data width in bits.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have port flush  input  1  synchronous discard of all held data.
REQ-005 SHALL have port in_valid  input  1  upstream offers in_data this cycle.
REQ-006 SHALL have port in_data  input  N  upstream payload.
REQ-007 SHALL have port in_ready  output  1  buffer accepts in_data this cycle.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-009 SHALL have port out_data  output  N  payload to downstream stage register.
REQ-010 SHALL have port out_ready  input  1  downstream (load enable of next register) consumes out_data this cycle.
REQ-011 SHALL have port occupancy  output  2  number of held words, 0..2.

Function
REQ-012 SHALL transfer on upstream side iff in_valid && in_ready at rising clk, and on downstream side iff out_valid && out_ready.
REQ-013 SHALL implement states EMPTY (0 words), BUSY (main entry valid), FULL (main + skid entries valid).
REQ-014 SHALL drive in_ready = (state != FULL), out_valid = (state != EMPTY), out_data = main entry, all decoded from registered state only (no combinational in->out path).
REQ-015 EMPTY: in_valid -> BUSY, main <= in_data; else stay.
REQ-016 BUSY: in_valid && out_ready -> BUSY, main <= in_data; in_valid && !out_ready -> FULL, skid <= in_data; !in_valid && out_ready -> EMPTY; else hold.
REQ-017 FULL: out_ready -> BUSY, main <= skid; else hold; in_data ignored (in_ready low).
REQ-018 SHALL preserve strict FIFO order; no word duplicated or dropped except by flush/reset.
REQ-019 SHALL give latency of exactly 1 cycle from upstream accept to out_valid when EMPTY.
REQ-020 SHALL sustain 1 word/cycle throughput while out_ready held high.
REQ-021 flush=1 SHALL force EMPTY next cycle, clear main and skid to 0, ignore simultaneous in_valid/out_ready; handshakes in that cycle are not transfers.
REQ-022 occupancy SHALL equal 0/1/2 for EMPTY/BUSY/FULL.
REQ-023 out_data SHALL remain stable while out_valid && !out_ready.

Reset
REQ-024 rst=0 at rising clk SHALL set state EMPTY, main=0, skid=0; priority over flush and all handshakes.
REQ-025 Post-reset outputs SHALL be: in_ready=1, out_valid=0, out_data=0, occupancy=0.
REQ-026 Reset mid-transfer SHALL discard held words with no partial update.

Structure
REQ-027 Shared package stage_pkg SHALL hold the state enum typedef (EMPTY, BUSY, FULL) and DATA_W default 24.
REQ-028 One sub-module SHALL be used: skid_entry, an N-bit data register with synchronous active-low clear and load enable, instantiated twice (main, skid).

Verification
REQ-029 Reset: hold rst=0 two cycles with in_valid=1, in_data=24'hABCDEF -> out_valid=0, out_data=0, in_ready=1, occupancy=0.
REQ-030 Single pass: in 24'h000123 in EMPTY with out_ready=1 -> out_valid=1, out_data=24'h000123 next cycle, then EMPTY.
REQ-031 Backpressure: out_ready=0, push 24'h000001, 24'h000002 -> occupancy=2, in_ready=0; third word 24'h000003 not accepted; release out_ready -> outputs 1 then 2, in order.
REQ-032 Streaming: 16 words 24'h000000..24'h00000F, out_ready=1 every cycle -> 16 outputs on consecutive cycles, in_ready never low.
REQ-033 Flush while FULL with in_valid=1 -> next cycle EMPTY, out_valid=0, out_data=0, flushed and concurrent words never appear.
REQ-034 Random valid/ready toggling 1000 cycles vs scoreboard queue -> zero order/data mismatches, occupancy always matches model.
